count_seq: RTL and testbench
============================

# count_seq

Run-control sequencer for the board's prescaled display counter. It owns the clock-enable prescaler and the 7-bit count register and runs them under an IDLE/RUN/PAUSE/DONE state machine. Software/button-side start, pause, clear and single-step requests come in; the count, a one-cycle tick and the status flags go out. It sits between the input-conditioning logic and the display driver.

## Interface
- TICK_DIV, 250000: clk cycles per count tick; must be ≥2.
- DIV_W, 18: prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse. From IDLE/DONE: begin a run. From PAUSE: resume.
- pause  in  1  single-cycle pulse. In RUN: freeze.
- clear  in  1  single-cycle pulse. Abort to IDLE with count 0.
- step  in  1  single-cycle pulse. In IDLE/PAUSE: advance count by one.
- limit  in  7  terminal count, 0..127; sampled live.
- auto_wrap  in  1  1: wrap to 0 at limit and keep running. 0: stop in DONE at limit.
- count  out  7  current count, registered.
- tick  out  1  high for exactly the cycle in which a prescaler-driven count update becomes visible.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level).
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Prescaler div advances only in RUN. It counts 0..TICK_DIV-1, then wraps to 0. Terminal value = "tick event".
- Tick event / step advance rule:
  - If count ≥ limit: with auto_wrap=1, count←0 and state is unchanged; with auto_wrap=0, count is held and state←DONE.
  - Otherwise count←count+1.
- Request priority when pulses coincide: clear > start > pause > step. Lower-priority requests in the same cycle are dropped.
- clear, any state: count←0, div←0, state←IDLE.
- start:
  - IDLE→RUN: div←0, count unchanged.
  - DONE→RUN: count←0, div←0.
  - PAUSE→RUN: div kept, so the tick phase resumes exactly.
  - RUN: ignored.
- pause: RUN→PAUSE, div held. Ignored in other states.
- step: valid in IDLE and PAUSE; applies the advance rule. A step that reaches the limit with auto_wrap=0 moves to DONE. Ignored in RUN and DONE. Step never asserts tick.
- A tick event in the same cycle as pause: the tick advance is taken and the state becomes PAUSE.
- A tick event in the same cycle as clear: clear wins and no tick is emitted.
- limit lowered below count mid-run: the next advance treats the count as at limit (≥ compare). The count never runs past a stale limit.
- limit=0: count stays 0. With auto_wrap=1, tick still pulses every TICK_DIV cycles. With auto_wrap=0, the first tick enters DONE.
- Reset values: count=0, div=0, tick=0, busy=0, done=0, state=IDLE.

## Timing
- All outputs are registered and change only on the rising clk edge or on async reset assertion.
- Request sampled at edge N: the resulting state, count and busy/done are visible after edge N (one-cycle latency).
- First tick after start at edge N: at edge N+TICK_DIV.
- Subsequent ticks: every TICK_DIV cycles while in RUN.
- Resume from pause: the remaining ticks keep the pre-pause phase. Example: paused with div=d, resumed at edge M → next tick at edge M+(TICK_DIV-1-d)+1.
- tick is high for exactly one cycle, coincident with the new count value.
- Reset asserted mid-run: outputs go to their reset values immediately.
- After rstn deassertion: the block takes no action until the first request.

## Test plan
- Sim TICK_DIV=4, limit=5, auto_wrap=0. Pulse start → tick every 4 cycles; count 1,2,3,4,5; done=1, busy=0, state=3 on the 5th tick; no further ticks.
- auto_wrap=1, limit=2, run 4 ticks → count 1,2,0,1; state stays RUN.
- RUN with div=1, pause for 10 cycles, then start → count frozen during pause; next tick 3 cycles after the resume edge.
- Coincident start+clear in PAUSE → state IDLE, count 0. Coincident pause with a tick event → count advances, state PAUSE.
- IDLE, limit=3, auto_wrap=0, three step pulses → count 1,2,3; tick never asserted; state DONE after the third. A start then gives count 0, RUN.
- At count=9, drop limit to 4 → next tick gives DONE with count 9 (auto_wrap=0). Repeat with auto_wrap=1 → count 0.
- Pulse rstn low mid-run, asynchronous to clk → all outputs at their reset values before the next clk edge.

Source files
------------

// File: rtl/count_seq.sv
// Run-control sequencer for the prescaled display counter: owns the tick
// prescaler and the 7-bit count and runs them under IDLE/RUN/PAUSE/DONE.
module count_seq #(
   parameter int TICK_DIV = 250000,
   parameter int DIV_W    = 18
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       step,
   input  logic [6:0] limit,
   input  logic       auto_wrap,
   output logic [6:0] count,
   output logic       tick,
   output logic       busy,
   output logic       done,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [6:0]       count_q, count_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             req_start;
   logic             req_pause;
   logic             req_step;
   logic             tick_ev;
   logic             at_limit;
   logic [6:0]       count_inc;
   logic [6:0]       adv_count;
   logic             adv_done;

   // Only the highest-priority pulse is considered; the rest are dropped
   // even when the winner turns out to be a no-op in the current state.
   assign req_start = start & ~clear;
   assign req_pause = pause & ~clear & ~start;
   assign req_step  = step & ~clear & ~start & ~pause;

   assign tick_ev   = (state_q == S_RUN) && (div_q == DIV_LAST);

   // Shared advance rule for tick events and steps. Reaching the limit, or
   // already sitting at/above a lowered limit, terminates unless wrapping.
   assign at_limit  = (count_q >= limit);
   assign count_inc = count_q + 7'd1;
   assign adv_count = at_limit ? (auto_wrap ? 7'd0 : count_q) : count_inc;
   assign adv_done  = ~auto_wrap & (at_limit | (count_inc == limit));

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      count_d = count_q;
      tick_d  = 1'b0;

      if (clear) begin
         state_d = S_IDLE;
         count_d = 7'd0;
         div_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_start) begin
                  state_d = S_RUN;
                  div_d   = '0;
               end else if (req_step) begin
                  count_d = adv_count;
                  if (adv_done) state_d = S_DONE;
               end
            end
            S_PAUSE: begin
               if (req_start) begin
                  state_d = S_RUN;
               end else if (req_step) begin
                  count_d = adv_count;
                  if (adv_done) state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (req_start) begin
                  state_d = S_RUN;
                  count_d = 7'd0;
                  div_d   = '0;
               end
            end
            S_RUN: begin
               // A tick coinciding with pause still lands; DONE outranks PAUSE.
               if (tick_ev) begin
                  count_d = adv_count;
                  div_d   = '0;
                  tick_d  = 1'b1;
                  if (adv_done) begin
                     state_d = S_DONE;
                  end else if (req_pause) begin
                     state_d = S_PAUSE;
                  end
               end else if (req_pause) begin
                  state_d = S_PAUSE;
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         count_q <= 7'd0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign state = state_q;

endmodule

// File: tb/tb_count_seq.sv
// Bench for count_seq: directed scenarios with literal expectations, then a
// randomized run, all checked every cycle against a behavioural model.
module tb_count_seq;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       clear = 1'b0;
   logic       step = 1'b0;
   logic [6:0] limit = 7'd0;
   logic       auto_wrap = 1'b0;
   logic [6:0] count;
   logic       tick;
   logic       busy;
   logic       done;
   logic [1:0] state;

   int compared = 0;
   int mismatched = 0;
   bit check_en = 1'b0;

   // Model: mode 0 idle, 1 run, 2 pause, 3 done; phase = cycles into period.
   int m_mode = 0;
   int m_count = 0;
   int m_phase = 0;
   int m_tick = 0;

   int exp2[4] = '{1, 2, 0, 1};

   count_seq #(.TICK_DIV(TD), .DIV_W(2)) dut (
      .clk(clk), .rstn(rstn), .start(start), .pause(pause), .clear(clear),
      .step(step), .limit(limit), .auto_wrap(auto_wrap), .count(count),
      .tick(tick), .busy(busy), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_advance(input int lim, input bit wrap);
      if (m_count >= lim) begin
         if (wrap) m_count = 0;
         else m_mode = 3;
      end else begin
         m_count = m_count + 1;
         if (!wrap && m_count == lim) m_mode = 3;
      end
   endtask

   task automatic model_step(input bit s, input bit p, input bit c, input bit t,
                             input int lim, input bit wrap);
      int req;
      bit period_end;
      req = c ? 1 : s ? 2 : p ? 3 : t ? 4 : 0;
      period_end = (m_mode == 1) && (m_phase == TD - 1);
      m_tick = 0;
      if (req == 1) begin
         m_mode = 0; m_count = 0; m_phase = 0;
      end else if (m_mode == 1) begin
         if (period_end) begin
            m_phase = 0;
            m_tick = 1;
            model_advance(lim, wrap);
            if (m_mode == 1 && req == 3) m_mode = 2;
         end else if (req == 3) begin
            m_mode = 2;
         end else begin
            m_phase = m_phase + 1;
         end
      end else if (req == 2) begin
         if (m_mode == 3) m_count = 0;
         if (m_mode != 2) m_phase = 0;
         m_mode = 1;
      end else if (req == 4 && (m_mode == 0 || m_mode == 2)) begin
         model_advance(lim, wrap);
      end
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_mode = 0; m_count = 0; m_phase = 0; m_tick = 0;
      end else begin
         model_step(start, pause, clear, step, int'(limit), auto_wrap);
      end
      #1;
      if (check_en) begin
         checkOutput("model_count", int'(count), m_count);
         checkOutput("model_tick", int'(tick), m_tick);
         checkOutput("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
         checkOutput("model_done", int'(done), (m_mode == 3) ? 1 : 0);
         checkOutput("model_state", int'(state), m_mode);
      end
   end

   task automatic applyStimulus(input bit s, input bit p, input bit c, input bit t);
      start = s; pause = p; clear = c; step = t;
      @(negedge clk);
      start = 1'b0; pause = 1'b0; clear = 1'b0; step = 1'b0;
   endtask

   task automatic check_all(input string name, input int c, input int tk,
                            input int b, input int d, input int st);
      checkOutput({name, "_count"}, int'(count), c);
      checkOutput({name, "_tick"}, int'(tick), tk);
      checkOutput({name, "_busy"}, int'(busy), b);
      checkOutput({name, "_done"}, int'(done), d);
      checkOutput({name, "_state"}, int'(state), st);
   endtask

   initial begin
      int ticks;
      int first;
      int tcount;
      int tstate;
      bit frozen;

      repeat (3) @(negedge clk);
      check_all("reset", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      check_en = 1'b1;
      @(negedge clk);

      $display("[TB] run to limit 5 without wrap");
      limit = 7'd5; auto_wrap = 1'b0;
      applyStimulus(1, 0, 0, 0);
      ticks = 0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (tick) begin
            ticks++;
            checkOutput("t1_tick_pos", i, TD * ticks);
            checkOutput("t1_tick_val", int'(count), ticks);
         end
      end
      checkOutput("t1_ticks", ticks, 5);
      check_all("t1_end", 5, 0, 0, 1, 3);

      $display("[TB] auto wrap at limit 2");
      limit = 7'd2; auto_wrap = 1'b1;
      applyStimulus(1, 0, 0, 0);
      checkOutput("t2_restart_count", int'(count), 0);
      ticks = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (tick) begin
            if (ticks < 4) checkOutput("t2_tick_val", int'(count), exp2[ticks]);
            ticks++;
         end
      end
      checkOutput("t2_ticks", ticks, 4);
      checkOutput("t2_state", int'(state), 1);

      $display("[TB] pause with div=1 and resume");
      applyStimulus(0, 0, 1, 0);
      limit = 7'd100; auto_wrap = 1'b0;
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t3_paused", int'(state), 2);
      frozen = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tick || count != 7'd0) frozen = 1'b0;
      end
      checkOutput("t3_frozen", int'(frozen), 1);
      applyStimulus(1, 0, 0, 0);
      first = -1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (tick && first < 0) first = i;
      end
      checkOutput("t3_resume_tick", first, 3);

      $display("[TB] coincident requests");
      applyStimulus(0, 1, 0, 0);
      checkOutput("t4_pause_state", int'(state), 2);
      applyStimulus(1, 0, 1, 0);
      check_all("t4_start_clear", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      applyStimulus(0, 1, 0, 0);
      check_all("t4_tick_pause", 1, 1, 0, 0, 2);

      $display("[TB] single steps to limit 3");
      applyStimulus(0, 0, 1, 0);
      limit = 7'd3; auto_wrap = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(0, 0, 0, 1);
         check_all("t5_step", k, 0, 0, (k == 3) ? 1 : 0, (k == 3) ? 3 : 0);
      end
      applyStimulus(1, 0, 0, 0);
      check_all("t5_restart", 0, 0, 1, 0, 1);

      $display("[TB] limit lowered below count");
      for (int w = 0; w < 2; w++) begin
         applyStimulus(0, 0, 1, 0);
         limit = 7'd20; auto_wrap = w[0];
         for (int k = 0; k < 9; k++) applyStimulus(0, 0, 0, 1);
         checkOutput("t6_stepped", int'(count), 9);
         applyStimulus(1, 0, 0, 0);
         limit = 7'd4;
         first = -1; tcount = -1; tstate = -1;
         for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (tick && first < 0) begin
               first = i; tcount = int'(count); tstate = int'(state);
            end
         end
         checkOutput("t6_tick_pos", first, TD);
         checkOutput("t6_count", tcount, (w == 0) ? 9 : 0);
         checkOutput("t6_state", tstate, (w == 0) ? 3 : 1);
      end

      $display("[TB] asynchronous reset mid-run");
      @(posedge clk);
      #3 rstn = 1'b0;
      #1 check_all("t7_async", 0, 0, 0, 0, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check_all("t7_quiet", 0, 0, 0, 0, 0);

      $display("[TB] randomized requests");
      for (int n = 0; n < 4000; n++) begin
         start = ($urandom_range(0, 24) == 0);
         pause = ($urandom_range(0, 24) == 0);
         clear = ($urandom_range(0, 99) == 0);
         step  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 63) == 0) limit = 7'($urandom_range(0, 12));
         if ($urandom_range(0, 127) == 0) auto_wrap = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start = 1'b0; pause = 1'b0; clear = 1'b0; step = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
